ext_unit: RTL and testbench
===========================

# ext_unit

Parametrised, pipelined immediate-extension unit for the Lapido datapath. It sits between instruction decode and the ALU operand mux and replaces the single-width combinational sign extender. It widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper-placement, or scaled branch offset. Results are registered behind a valid/ready handshake, with a 2-entry skid so that decode is never stalled combinationally by the ALU side.

## Interface
- IN_W, 16, immediate width; must satisfy 2 ≤ IN_W < OUT_W.
- OUT_W, 32, extended result width.
- SHIFT, 2, left shift applied in BRANCH mode; must satisfy SHIFT < OUT_W − IN_W.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  immediate and mode are valid this cycle.
- in_ready  out  1  unit can accept an input this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extension mode (encodings under Operation).
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_W  extended result.

## Operation
- Modes:
  - 2'b00 ZERO: upper OUT_W−IN_W bits are 0.
  - 2'b01 SIGN: upper bits replicate in_imm[IN_W−1].
  - 2'b10 UPPER: in_imm sits in bits [OUT_W−1 : OUT_W−IN_W]; the low bits are 0.
  - 2'b11 BRANCH: sign-extend, then shift left by SHIFT. Bits shifted out are discarded and the low SHIFT bits are 0.
- Storage:
  - Output register: out_valid and out_data.
  - Skid register: skid_valid and skid_data.
  - Both hold already-extended values.
- Accept and release rules:
  - An input is accepted when in_valid && in_ready.
  - The output is released when out_valid && out_ready.
- State (skid_valid, out_valid) transitions:
  - EMPTY (0,0): on accept, load the output register → ONE.
  - ONE (0,1):
    - Accept with release: output register takes the new value; stay ONE.
    - Release only: → EMPTY.
    - Accept without release: the new value goes to skid → FULL.
  - FULL (1,1):
    - in_ready is 0, so no accept.
    - On release: skid moves into the output register and skid_valid clears → ONE.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- in_ready is registered and equals !skid_valid.
- out_data and skid_data are undefined-free: when their valid bit is clear they hold the last value or 0, never X.
- Reset, including mid-operation:
  - skid_valid = 0, out_valid = 0, out_data = 0, skid_data = 0, in_ready = 1.
  - In-flight results are discarded.

## Timing
- Latency: one cycle from accept to out_valid.
- Throughput: one result per cycle while out_ready = 1.
- Same-edge accept and release in ONE is legal and must not stall.
- In FULL, in_ready deasserts on the cycle after the skid fills; the input is not re-sampled until in_ready is 1.
- in_imm and in_mode are sampled only on an accept edge. Changes while in_valid = 0 are ignored.
- out_valid, once high, stays high, with out_data stable, until released.
- rst_n assertion takes effect immediately. Deassertion is synchronised externally; the first accept is allowed on the first clk edge after release.

## Structure
- Package ext_pkg holds:
  - The mode localparams: EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_BRANCH.
  - The 2-bit mode typedef, ext_mode_t.
- Sub-module ext_core: purely combinational. It takes IN_W, OUT_W and SHIFT and maps (imm, mode) → OUT_W-bit result. It is instantiated once, on the input side, so both registers store final values.
- The top level holds the handshake registers and a parameter legality check that errors at elaboration.

## Test plan
- Modes at default parameters:
  - SIGN 16'h8001 → 32'hFFFF8001.
  - ZERO 16'h8001 → 32'h00008001.
  - UPPER 16'h1234 → 32'h12340000.
  - BRANCH 16'hFFFF → 32'hFFFFFFFC.
  - SIGN 16'h7FFF → 32'h00007FFF.
- Streaming: 8 back-to-back inputs with out_ready held at 1 → 8 results on consecutive cycles, in order, one cycle behind.
- Backpressure:
  - Stimulus: send A = 16'h0001 and B = 16'h0002 (SIGN) with out_ready = 0 for 3 cycles.
  - Response: out_data holds A; in_ready drops after B is accepted; C is not accepted while held.
  - After out_ready rises: A, then B, then C emerge on consecutive cycles.
- Same-edge accept and release in ONE: out_valid stays high with no bubble, and the new value appears the next cycle.
- Reset mid-operation: assert rst_n = 0 in FULL → out_valid = 0, out_data = 0 and in_ready = 1 immediately. No stale result appears after release.
- Non-default parameters, IN_W = 12, OUT_W = 24, SHIFT = 1: BRANCH 12'h800 → 24'hFFF000, and UPPER 12'hABC → 24'hABC000.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared mode encodings for the immediate-extension unit.
package ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO   = 2'b00;
    localparam ext_mode_t EXT_SIGN   = 2'b01;
    localparam ext_mode_t EXT_UPPER  = 2'b10;
    localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate widener: (imm, mode) -> OUT_W-bit extended value.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] result
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;

    assign zext  = {{PAD_W{1'b0}}, imm};
    assign sext  = {{PAD_W{imm[IN_W-1]}}, imm};
    assign upper = {imm, {PAD_W{1'b0}}};

    always_comb begin
        result = zext;
        unique case (mode)
            EXT_ZERO:   result = zext;
            EXT_SIGN:   result = sext;
            EXT_UPPER:  result = upper;
            EXT_BRANCH: result = sext << SHIFT;
            default:    result = zext;
        endcase
    end

endmodule

// File: rtl/ext_unit.sv
// Registered immediate-extension stage with a 2-entry skid (output reg + skid reg).
module ext_unit
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    if (IN_W < 2 || IN_W >= OUT_W || SHIFT >= OUT_W - IN_W) begin : g_bad_params
        $error("ext_unit: illegal parameters (need 2 <= IN_W < OUT_W, SHIFT < OUT_W - IN_W)");
    end

    logic [OUT_W-1:0] ext_val;

    ext_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
    ) u_core (
        .imm   (in_imm),
        .mode  (in_mode),
        .result(ext_val)
    );

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q,  in_ready_d;

    logic accept;
    logic release_out;

    assign accept      = in_valid && in_ready_q;
    assign release_out = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (!out_valid_q) begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_val;
            end
        end else if (!skid_valid_q) begin
            if (accept && release_out) begin
                out_data_d = ext_val;
            end else if (release_out) begin
                out_valid_d = 1'b0;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = ext_val;
            end
        end else if (release_out) begin
            // in_ready is low while full, so nothing new can arrive here
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_ext_unit.sv
// Directed + randomized bench for ext_unit, checked against a FIFO-queue reference model.
module tb_ext_unit;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [31:0] out_data;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [11:0] in_imm2;
    logic [1:0]  in_mode2;
    logic [23:0] out_data2;

    int errors = 0;
    int checks = 0;
    logic [31:0] q[$];

    ext_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    ext_unit #(.IN_W(12), .OUT_W(24), .SHIFT(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_mode(in_mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: interpret the immediate as a number, then reduce mod 2^ow.
    function automatic logic [31:0] model(input int unsigned imm, input int mode,
                                          input int iw, input int ow, input int sh);
        longint m, v;
        m = 64'sd1 <<< ow;
        v = longint'(imm);
        case (mode)
            0: v = v;
            1: if (v >= (64'sd1 <<< (iw - 1))) v = v - (64'sd1 <<< iw);
            2: v = v * (64'sd1 <<< (ow - iw));
            default: begin
                if (v >= (64'sd1 <<< (iw - 1))) v = v - (64'sd1 <<< iw);
                v = v * (64'sd1 <<< sh);
            end
        endcase
        while (v < 0) v = v + m;
        v = v % m;
        return 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: check outputs, drive inputs, advance model, wait one cycle.
    task automatic step(input logic iv, input logic [15:0] imm, input logic [1:0] md,
                        input logic ordy);
        logic acc, rel;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        in_valid  = iv;
        in_imm    = imm;
        in_mode   = md;
        out_ready = ordy;
        acc = iv && (q.size() < 2);
        rel = (q.size() > 0) && ordy;
        if (rel) void'(q.pop_front());
        if (acc) q.push_back(model(imm, md, 16, 32, 2));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_imm = 0; in_mode = 0; out_ready = 0;
        in_valid2 = 0; in_imm2 = 0; in_mode2 = 0; out_ready2 = 1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode vectors, each expected one cycle after accept
        step(1, 16'h8001, 2'b01, 1); chk("sign_8001", out_data, 32'hFFFF8001);
        step(1, 16'h8001, 2'b00, 1); chk("zero_8001", out_data, 32'h00008001);
        step(1, 16'h1234, 2'b10, 1); chk("upper_1234", out_data, 32'h12340000);
        step(1, 16'hFFFF, 2'b11, 1); chk("branch_ffff", out_data, 32'hFFFFFFFC);
        step(1, 16'h7FFF, 2'b01, 1); chk("sign_7fff", out_data, 32'h00007FFF);
        step(0, 16'h0, 2'b00, 1);

        // 8 back-to-back; each result visible the cycle after its accept
        for (int i = 0; i < 8; i++) begin
            step(1, 16'(16'h0100 + i), 2'b01, 1);
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_data", out_data, 32'(16'h0100 + i));
        end
        step(0, 16'h0, 2'b00, 1);

        // Backpressure: A, B fill both slots, C held off
        step(1, 16'h0001, 2'b01, 0);
        step(1, 16'h0002, 2'b01, 0);
        chk("bp_hold_a", out_data, 32'h1);
        chk("bp_ready_low", 32'(in_ready), 0);
        step(1, 16'h0003, 2'b01, 0);
        step(1, 16'h0003, 2'b01, 1);
        chk("bp_b", out_data, 32'h2);
        step(1, 16'h0003, 2'b01, 1);
        chk("bp_c", out_data, 32'h3);
        step(0, 16'h0, 2'b00, 1);

        // Same-edge accept+release in ONE: no bubble
        step(1, 16'h0010, 2'b00, 1);
        step(1, 16'h0020, 2'b00, 1);
        chk("same_edge_valid", 32'(out_valid), 1);
        chk("same_edge_data", out_data, 32'h20);
        step(0, 16'h0, 2'b00, 1);

        // Reset while FULL
        step(1, 16'h0005, 2'b00, 0);
        step(1, 16'h0006, 2'b00, 0);
        chk("pre_rst_full", 32'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        q.delete();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 16'h0, 2'b00, 1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) step(0, 16'h0, 2'b00, 1);

        // Non-default parameters (12 -> 24, shift 1), consumer always ready
        in_valid = 0;
        in_valid2 = 1; in_imm2 = 12'h800; in_mode2 = 2'b11;
        @(negedge clk);
        chk("p2_valid", 32'(out_valid2), 1);
        chk("p2_branch_800", 32'(out_data2), 32'hFFF000);
        in_imm2 = 12'hABC; in_mode2 = 2'b10;
        @(negedge clk);
        chk("p2_upper_abc", 32'(out_data2), 32'hABC000);
        for (int i = 0; i < 40; i++) begin
            logic [11:0] r_imm;
            logic [1:0]  r_md;
            r_imm = 12'($urandom);
            r_md  = 2'($urandom_range(0, 3));
            in_imm2 = r_imm; in_mode2 = r_md;
            @(negedge clk);
            chk("p2_rand", 32'(out_data2), model(r_imm, r_md, 12, 24, 1));
        end
        in_valid2 = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
